// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_PASS_B = 3'b011,
    OP_OR     = 3'b100,
    OP_XOR    = 3'b101,
    OP_SHL    = 3'b110,
    OP_MUL    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import alu_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_step;

  // done and product are combinational so the caller can latch the final sum on the last step edge
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (count_q == LAST);
    product  = acc_step;
    busy_d   = busy_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      count_d  = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish in one cycle, MUL iterates; result held until handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             ovf_flag
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  flags_t             flags_q, flags_d;

  alu_op_e            op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign op        = alu_op_e'(alu_op);
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // The extra top bit of shl_ext catches the last bit shifted out; it stays 0 for a zero shift.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    shl_ext   = {1'b0, a} << b[SW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:    alu_res = a & b;
      OP_PASS_B: alu_res = b;
      OP_OR:     alu_res = a | b;
      OP_XOR:    alu_res = a ^ b;
      OP_SHL: begin
        alu_res   = shl_ext[WIDTH-1:0];
        alu_carry = shl_ext[WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = BUSY;
          end else begin
            result_d      = alu_res;
            flags_d.zero  = (alu_res == '0);
            flags_d.carry = alu_carry;
            flags_d.neg   = alu_res[WIDTH-1];
            flags_d.ovf   = alu_ovf;
            state_d       = HOLD;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          result_d      = mul_product[WIDTH-1:0];
          flags_d.zero  = (mul_product[WIDTH-1:0] == '0);
          flags_d.carry = |mul_product[2*WIDTH-1:WIDTH];
          flags_d.neg   = mul_product[WIDTH-1];
          flags_d.ovf   = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result     = result_q;
  assign zero_flag  = flags_q.zero;
  assign carry_flag = flags_q.carry;
  assign neg_flag   = flags_q.neg;
  assign ovf_flag   = flags_q.ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=8; expected values are hand-computed.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       alu_op = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             zero_flag, carry_flag, neg_flag, ovf_flag;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .neg_flag   (neg_flag),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flags_now();
    return {zero_flag, carry_flag, neg_flag, ovf_flag};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // flags are packed {zero, carry, neg, ovf}; hold = cycles out_ready stays low in HOLD
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [2:0] top, input logic [7:0] exp_res,
                       input logic [3:0] exp_flg, input int exp_lat, input int hold);
    int  lat;
    bit  seen;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, in_ready, 1);
    a = ta; b = tb_v; alu_op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_v; alu_op = top ^ 3'b101;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    check_eq({tag, ".done"}, seen, 1);
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".result"}, result, exp_res);
    check_eq({tag, ".flags"}, flags_now(), exp_flg);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'h5A + 8'(i); b = 8'h33; alu_op = OP_ADD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq({tag, ".hold_valid"}, out_valid, 1);
      check_eq({tag, ".hold_ready"}, in_ready, 0);
      check_eq({tag, ".hold_result"}, result, exp_res);
      check_eq({tag, ".hold_flags"}, flags_now(), exp_flg);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ".released"}, out_valid, 0);
    $display("%-10s a=%02h b=%02h op=%0d -> result=%02h zcnv=%04b lat=%0d", tag, ta, tb_v, top,
             result, flags_now(), lat);
  endtask

  initial begin
    #2;
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.result", result, 0);
    check_eq("rst.flags", flags_now(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst.in_ready", in_ready, 1);

    do_op("add_ff01", 8'hFF, 8'h01, OP_ADD,    8'h00, 4'b1100, 1, 0);
    do_op("add_7f01", 8'h7F, 8'h01, OP_ADD,    8'h80, 4'b0011, 1, 0);
    do_op("sub_8001", 8'h80, 8'h01, OP_SUB,    8'h7F, 4'b0001, 1, 0);
    do_op("sub_0102", 8'h01, 8'h02, OP_SUB,    8'hFF, 4'b0110, 1, 0);
    do_op("and",      8'hF0, 8'h3C, OP_AND,    8'h30, 4'b0000, 1, 0);
    do_op("pass_b",   8'h12, 8'h9C, OP_PASS_B, 8'h9C, 4'b0010, 1, 0);
    do_op("or",       8'h0F, 8'h30, OP_OR,     8'h3F, 4'b0000, 1, 0);
    do_op("xor_hold", 8'hAA, 8'hFF, OP_XOR,    8'h55, 4'b0000, 1, 5);
    do_op("mul_1010", 8'h10, 8'h10, OP_MUL,    8'h00, 4'b1100, 9, 0);
    do_op("mul_0f0f", 8'h0F, 8'h0F, OP_MUL,    8'hE1, 4'b0010, 9, 0);
    do_op("shl_4009", 8'h40, 8'h09, OP_SHL,    8'h80, 4'b0010, 1, 0);
    do_op("shl_8101", 8'h81, 8'h01, OP_SHL,    8'h02, 4'b0100, 1, 0);
    do_op("shl_8100", 8'h81, 8'h00, OP_SHL,    8'h81, 4'b0010, 1, 0);

    // reset three cycles into a multiply must drop it without a handshake
    @(negedge clk);
    a = 8'h0F; b = 8'h0F; alu_op = OP_MUL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst.out_valid", out_valid, 0);
    check_eq("midrst.result", result, 0);
    check_eq("midrst.flags", flags_now(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst.in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    check_eq("midrst.no_output", out_valid, 0);
    $display("midrst     MUL aborted, out_valid=%0b result=%02h", out_valid, result);

    do_op("add_0203", 8'h02, 8'h03, OP_ADD,    8'h05, 4'b0000, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal values 4..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: alu_op  input  3  opcode.
REQ-009 SHALL have port: out_valid  output  1  result and flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have ports: zero_flag, carry_flag, neg_flag, ovf_flag  output  1 each  registered flags.

Function
REQ-013 SHALL implement opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 PASS_B (result=b); 100 OR; 101 XOR; 110 SHL a<<b[clog2(WIDTH)-1:0]; 111 MUL, low WIDTH bits of unsigned a*b.
REQ-014 SHALL run an FSM with states IDLE, BUSY, HOLD; in_ready=1 only in IDLE; out_valid=1 only in HOLD.
REQ-015 SHALL accept an operation when in_valid && in_ready, capturing a, b and alu_op in that cycle; later input changes are ignored.
REQ-016 SHALL, for opcodes 000-110, go IDLE->HOLD on accept, with out_valid asserted on the next cycle (latency 1).
REQ-017 SHALL, for MUL, go IDLE->BUSY and run an iterative shift-add for exactly WIDTH cycles, then enter HOLD (out_valid WIDTH+1 cycles after accept).
REQ-018 SHALL hold result and flags stable in HOLD until out_valid && out_ready, then return to IDLE on the next cycle.
REQ-019 SHALL ignore in_valid while in BUSY or HOLD; a new accept is possible no earlier than the cycle after the HOLD handshake.
REQ-020 SHALL set zero_flag=(result==0) and neg_flag=result[WIDTH-1] for every opcode.
REQ-021 SHALL set carry_flag as follows: ADD, the carry-out; SUB, the borrow (a<b unsigned); SHL, the last bit shifted out (0 when the shift amount is 0); MUL, 1 if the upper WIDTH product bits are nonzero; otherwise 0.
REQ-022 SHALL set ovf_flag to two's-complement signed overflow for ADD/SUB, and to 0 for all other opcodes.
REQ-023 SHALL NOT raise an error on any opcode; all eight codes are defined.

Reset
REQ-024 SHALL, on rst asserted, immediately (asynchronously) force state=IDLE, out_valid=0, result=0 and all flags 0; in_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-025 SHALL, when rst asserts mid-BUSY or in HOLD, discard the in-flight operation with no output handshake.

Structure
REQ-026 SHALL place the opcode constants and the FSM state encoding in shared package alu_pkg; the existing combinational ALU opcode values 000-011 SHALL be unchanged.
REQ-027 SHALL implement MUL in sub-module alu_mul_iter (start/done, WIDTH-parameterised, 2*WIDTH accumulator).
REQ-028 SHALL compute ADD/SUB using a WIDTH+1-bit sum for carry/borrow.

Verification (WIDTH=8)
REQ-029 SHALL check: ADD a=FF b=01 -> result 00, zero=1, carry=1, ovf=0, out_valid 1 cycle after accept.
REQ-030 SHALL check: SUB a=80 b=01 -> 7F, ovf=1, carry=0, neg=0; SUB a=01 b=02 -> FF, carry=1, neg=1.
REQ-031 SHALL check: MUL a=10 b=10 -> 00, zero=1, carry=1, out_valid exactly 9 cycles after accept; MUL 0F*0F -> E1, carry=0.
REQ-032 SHALL check: SHL a=81 b=01 -> 02, carry=1; b=00 -> 81, carry=0.
REQ-033 SHALL check: out_ready held low 5 cycles in HOLD -> result/flags stable, in_ready=0, in_valid pulses ignored.
REQ-034 SHALL check: rst asserted 3 cycles into MUL -> out_valid=0 and result=00 immediately; after release, in_ready=1 and a fresh ADD 02+03 returns 05.
